// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce scheduler: the FSM state encoding,
// default timing constants and a small modulo-N index helper.
package debounce_pkg;

  // Scheduler states: waiting for a mismatch, timing one input, committing it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // 10 ms at 100 MHz; the timer must be able to hold DEBOUNCE_CYCLES-1.
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int CNT_W_DEF           = 20;

  // (a + b) mod n for 0 <= a, b < n, without a divider.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) begin
      s = s - n;
    end
    return s;
  endfunction

endpackage

// File: rtl/debounce_scheduler_rr_pick.sv
// Round-robin picker: finds the first set mismatch bit at or above the
// pointer, wrapping around, and reports whether any bit was set at all.
module rr_pick
  import debounce_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_mismatch,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Rotate the request vector so that bit 0 corresponds to the pointer;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;

  assign w_dbl = {i_mismatch, i_mismatch} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  // Priority-encode the rotated vector (lowest bit wins) and undo the rotation.
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IDX_W'(k);
      end
    end
    o_valid = |i_mismatch;
    o_idx   = IDX_W'(wrap_add(int'(i_ptr), int'(w_off), N));
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounce scheduler: one shared stability timer serves N synchronised
// switch inputs in round-robin order. A new clean level is committed only
// after the served input has held its new level for DEBOUNCE_CYCLES clocks.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN adds registered one-cycle
// rise/fall pulses that accompany each clean-level commit.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_INPUTS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int IDX_W           = $clog2(N_INPUTS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] noisy,
  output logic [N_INPUTS-1:0] clean,
  output logic                busy,
  output logic [IDX_W-1:0]    active_idx
`ifdef DEBOUNCE_EDGE_PULSE_EN
  ,
  output logic [N_INPUTS-1:0] rise,
  output logic [N_INPUTS-1:0] fall
`endif
);

  // Terminal timer value; reaching it with the level still held commits.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_INPUTS-1:0] r_sync1;
  logic [N_INPUTS-1:0] r_sync2;
  logic [N_INPUTS-1:0] r_clean;
  state_t              r_state;
  logic [CNT_W-1:0]    r_count;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_idx;
  logic                r_target;
  logic                r_busy;
  logic [IDX_W-1:0]    r_active_idx;

  logic [N_INPUTS-1:0] w_mismatch;
  logic                w_pick_valid;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [IDX_W-1:0]    w_next_ptr;
  logic                w_served_sync;

  assign w_mismatch    = r_sync2 ^ r_clean;
  assign w_next_ptr    = IDX_W'(wrap_add(int'(r_idx), 1, N_INPUTS));
  assign w_served_sync = r_sync2[r_idx];

  assign clean      = r_clean;
  assign busy       = r_busy;
  assign active_idx = r_active_idx;

  rr_pick #(
    .N     (N_INPUTS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_mismatch (w_mismatch),
    .i_ptr      (r_rr_ptr),
    .o_valid    (w_pick_valid),
    .o_idx      (w_pick_idx)
  );

  // Two-flop synchroniser; reset preloads both stages so nothing looks changed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= noisy;
      r_sync2 <= noisy;
    end else begin
      r_sync1 <= noisy;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic [N_INPUTS-1:0] r_rise;
  logic [N_INPUTS-1:0] r_fall;

  assign rise = r_rise;
  assign fall = r_fall;
`else
  // Without edge pulses the consumer edge-detects clean on its own.
`endif

  // Scheduler FSM: select a mismatching input, time its stability, commit it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_rr_ptr     <= '0;
      r_idx        <= '0;
      r_target     <= 1'b0;
      r_busy       <= 1'b0;
      r_active_idx <= '0;
      r_clean      <= noisy;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      r_rise       <= '0;
      r_fall       <= '0;
`endif
    end else begin
`ifdef DEBOUNCE_EDGE_PULSE_EN
      // Pulses last exactly one cycle unless a commit sets them below.
      r_rise <= '0;
      r_fall <= '0;
`endif
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_idx        <= w_pick_idx;
            r_target     <= r_sync2[w_pick_idx];
            r_count      <= '0;
            r_busy       <= 1'b1;
            r_active_idx <= w_pick_idx;
            r_state      <= TIMING;
          end
        end

        TIMING: begin
          // A bounce wins over reaching the terminal count.
          if (w_served_sync != r_target) begin
            r_count      <= '0;
            r_rr_ptr     <= w_next_ptr;
            r_busy       <= 1'b0;
            r_active_idx <= '0;
            r_state      <= IDLE;
          end else if (r_count == LAST_COUNT) begin
            r_state <= COMMIT;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        COMMIT: begin
          // The target always differs from the old clean level, so exactly
          // one of the edge pulses fires.
          r_clean[r_idx] <= r_target;
`ifdef DEBOUNCE_EDGE_PULSE_EN
          r_rise[r_idx]  <= r_target;
          r_fall[r_idx]  <= ~r_target;
`endif
          r_count      <= '0;
          r_rr_ptr     <= w_next_ptr;
          r_busy       <= 1'b0;
          r_active_idx <= '0;
          r_state      <= IDLE;
        end

        default: begin
          r_count      <= '0;
          r_busy       <= 1'b0;
          r_active_idx <= '0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed testbench for debounce_scheduler with N_INPUTS=4, DEBOUNCE_CYCLES=8.
// Stimulus changes on the falling edge; outputs are observed on the falling
// edge. With stimulus applied at falling edge k=0, the sampling rising edge
// precedes falling edge k=1, so an uncontended commit is visible at k=12.
module tb_debounce_scheduler;

  logic       clock;
  logic       reset;
  logic [3:0] noisy;
  logic [3:0] clean;
  logic       busy;
  logic [1:0] active_idx;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic [3:0] rise;
  logic [3:0] fall;
`endif

  int tests;
  int fails;

  debounce_scheduler #(
    .N_INPUTS        (4),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4),
    .IDX_W           (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .noisy      (noisy),
    .clean      (clean),
    .busy       (busy),
    .active_idx (active_idx)
`ifdef DEBOUNCE_EDGE_PULSE_EN
    ,
    .rise       (rise),
    .fall       (fall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply reset for one rising edge with the given pin levels, release it,
  // and return at the falling edge after the first unreset rising edge.
  task automatic do_reset(input logic [3:0] v);
    @(negedge clock);
    reset = 1'b1;
    noisy = v;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset(4'b0101);
    tests++;
    if (clean !== 4'b0101) begin
      fails++;
      $display("FAIL reset_clean: got %b expected %b", clean, 4'b0101);
    end
    tests++;
    if (busy !== 1'b0 || active_idx !== 2'd0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b idx=%0d expected busy=0 idx=0", busy, active_idx);
    end
`ifdef DEBOUNCE_EDGE_PULSE_EN
    tests++;
    if (rise !== 4'b0000 || fall !== 4'b0000) begin
      fails++;
      $display("FAIL reset_pulse: got rise=%b fall=%b expected 0000/0000", rise, fall);
    end
`endif
    repeat (4) @(negedge clock);
    tests++;
    if (clean !== 4'b0101 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_quiet: got clean=%b busy=%b expected 0101/0", clean, busy);
    end
    $display("[TB] reset: clean=%b busy=%b idx=%0d", clean, busy, active_idx);
  endtask

  task automatic test_rise();
    do_reset(4'b0000);
    noisy[2] = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clock);
      if (k == 5) begin
        tests++;
        if (busy !== 1'b1 || active_idx !== 2'd2) begin
          fails++;
          $display("FAIL rise_busy: got busy=%b idx=%0d expected busy=1 idx=2", busy, active_idx);
        end
      end
      if (k == 11) begin
        tests++;
        if (clean !== 4'b0000) begin
          fails++;
          $display("FAIL rise_early: got %b expected %b", clean, 4'b0000);
        end
      end
      if (k == 12) begin
        tests++;
        if (clean !== 4'b0100) begin
          fails++;
          $display("FAIL rise_commit: got %b expected %b", clean, 4'b0100);
        end
`ifdef DEBOUNCE_EDGE_PULSE_EN
        tests++;
        if (rise !== 4'b0100 || fall !== 4'b0000) begin
          fails++;
          $display("FAIL rise_pulse: got rise=%b fall=%b expected 0100/0000", rise, fall);
        end
`endif
      end
`ifdef DEBOUNCE_EDGE_PULSE_EN
      if (k == 13) begin
        tests++;
        if (rise !== 4'b0000 || fall !== 4'b0000) begin
          fails++;
          $display("FAIL rise_pulse_end: got rise=%b fall=%b expected 0000/0000", rise, fall);
        end
      end
`endif
    end
    $display("[TB] rise: clean=%b after 12 clocks", clean);
  endtask

  task automatic test_bounce();
    int  falls;
    bit  bad;
    logic prev_busy;
    falls     = 0;
    bad       = 1'b0;
    prev_busy = busy;
    for (int c = 0; c < 46; c++) begin
      if (c < 40 && (c % 5) == 0) noisy[1] = ~noisy[1];
      @(negedge clock);
      if (clean !== 4'b0100) bad = 1'b1;
      if (prev_busy && !busy) falls++;
      prev_busy = busy;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL bounce_clean: got a clean change expected clean held at %b", 4'b0100);
    end
    tests++;
    if (falls != 4) begin
      fails++;
      $display("FAIL bounce_aborts: got %0d busy drops expected 4", falls);
    end
    noisy[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 11) begin
        tests++;
        if (clean !== 4'b0100) begin
          fails++;
          $display("FAIL bounce_steady_early: got %b expected %b", clean, 4'b0100);
        end
      end
      if (k == 12) begin
        tests++;
        if (clean !== 4'b0110) begin
          fails++;
          $display("FAIL bounce_steady_commit: got %b expected %b", clean, 4'b0110);
        end
      end
    end
    $display("[TB] bounce: %0d aborts, clean=%b after steady level", falls, clean);
  endtask

  task automatic test_back_to_back();
    do_reset(4'b0110);
    noisy = 4'b1111;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clock);
      if (k == 5) begin
        tests++;
        if (busy !== 1'b1 || active_idx !== 2'd0) begin
          fails++;
          $display("FAIL b2b_first_idx: got busy=%b idx=%0d expected busy=1 idx=0", busy, active_idx);
        end
      end
      if (k == 12) begin
        tests++;
        if (clean !== 4'b0111) begin
          fails++;
          $display("FAIL b2b_first_commit: got %b expected %b", clean, 4'b0111);
        end
`ifdef DEBOUNCE_EDGE_PULSE_EN
        tests++;
        if (rise !== 4'b0001) begin
          fails++;
          $display("FAIL b2b_first_pulse: got rise=%b expected 0001", rise);
        end
`endif
      end
      if (k == 16) begin
        tests++;
        if (busy !== 1'b1 || active_idx !== 2'd3) begin
          fails++;
          $display("FAIL b2b_second_idx: got busy=%b idx=%0d expected busy=1 idx=3", busy, active_idx);
        end
      end
      if (k == 21) begin
        tests++;
        if (clean !== 4'b0111) begin
          fails++;
          $display("FAIL b2b_second_early: got %b expected %b", clean, 4'b0111);
        end
      end
      if (k == 22) begin
        tests++;
        if (clean !== 4'b1111) begin
          fails++;
          $display("FAIL b2b_second_commit: got %b expected %b", clean, 4'b1111);
        end
`ifdef DEBOUNCE_EDGE_PULSE_EN
        tests++;
        if (rise !== 4'b1000) begin
          fails++;
          $display("FAIL b2b_second_pulse: got rise=%b expected 1000", rise);
        end
`endif
      end
    end
    $display("[TB] back_to_back: clean=%b, input 0 then input 3", clean);
  endtask

  task automatic test_starve();
    bit found;
    bit bad;
    int at;
    found = 1'b0;
    bad   = 1'b0;
    at    = 0;
    do_reset(4'b1011);
    noisy[2] = 1'b1;
    noisy[1] = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clock);
      if (!found && clean[2] === 1'b1) begin
        found = 1'b1;
        at    = k;
      end
      if (clean[1] !== 1'b1) bad = 1'b1;
      if ((k % 3) == 0) noisy[1] = ~noisy[1];
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL starve_commit: got clean[2]=%b after 31 clocks expected 1", clean[2]);
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL starve_bouncer: got a clean[1] change expected clean[1] held at 1");
    end
    $display("[TB] starve: clean[2] committed at clock %0d", at);
  endtask

  task automatic test_reset_mid();
    bit quiet_bad;
    quiet_bad = 1'b0;
    do_reset(4'b0000);
    noisy[3] = 1'b1;
    repeat (8) @(negedge clock);
    tests++;
    if (busy !== 1'b1 || active_idx !== 2'd3) begin
      fails++;
      $display("FAIL mid_timing: got busy=%b idx=%0d expected busy=1 idx=3", busy, active_idx);
    end
    reset = 1'b1;
    noisy = 4'b0101;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (clean !== 4'b0101 || busy !== 1'b0 || active_idx !== 2'd0) begin
      fails++;
      $display("FAIL mid_reset: got clean=%b busy=%b idx=%0d expected 0101/0/0", clean, busy, active_idx);
    end
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (clean !== 4'b0101 || busy !== 1'b0) quiet_bad = 1'b1;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      if (rise !== 4'b0000 || fall !== 4'b0000) quiet_bad = 1'b1;
`endif
    end
    tests++;
    if (quiet_bad) begin
      fails++;
      $display("FAIL mid_quiet: got activity after reset expected clean=0101 busy=0 no pulses");
    end
    $display("[TB] reset_mid: clean=%b busy=%b", clean, busy);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    noisy = 4'b0000;
    test_reset();
    test_rise();
    test_bounce();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
